// File: rtl/spi_dac_master.sv
// SPI mode-0 master for the board DAC: frames commands under chip select,
// shifts in the DAC readback on MISO, and generates the DAC clear pulse.
module spi_dac_master #(
  parameter int DATA_WIDTH = 32,
  parameter int CLK_DIV    = 2,
  parameter int CLR_CYCLES = 4,
  parameter int CS_IDLE    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_enable,
  input  logic                  clr_req,
  input  logic                  spi_miso,
  output logic                  spi_sck,
  output logic                  spi_mosi,
  output logic                  dac_cs_n,
  output logic                  dac_clr_n,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] rx_data
);

  localparam int CMAX_A = (CLK_DIV > CLR_CYCLES) ? CLK_DIV : CLR_CYCLES;
  localparam int CMAX   = (CMAX_A > CS_IDLE) ? CMAX_A : CS_IDLE;
  localparam int CW     = $clog2(CMAX + 1);
  localparam int BW     = $clog2(DATA_WIDTH);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    HOLD,
    GAP,
    CLEAR
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [DATA_WIDTH-1:0] tx_sr_q, tx_sr_d;
  logic [DATA_WIDTH-1:0] rx_sr_q, rx_sr_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  sck_q, sck_d;
  logic                  mosi_q, mosi_d;
  logic                  cs_n_q, cs_n_d;
  logic                  clr_n_q, clr_n_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      tx_sr_q   <= '0;
      rx_sr_q   <= '0;
      rx_data_q <= '0;
      sck_q     <= 1'b0;
      mosi_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      clr_n_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      tx_sr_q   <= tx_sr_d;
      rx_sr_q   <= rx_sr_d;
      rx_data_q <= rx_data_d;
      sck_q     <= sck_d;
      mosi_q    <= mosi_d;
      cs_n_q    <= cs_n_d;
      clr_n_q   <= clr_n_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    tx_sr_d   = tx_sr_q;
    rx_sr_d   = rx_sr_q;
    rx_data_d = rx_data_q;
    sck_d     = sck_q;
    mosi_d    = mosi_q;
    cs_n_d    = cs_n_q;
    clr_n_d   = clr_n_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
          cnt_d   = CW'(CLR_CYCLES - 1);
          clr_n_d = 1'b0;
          busy_d  = 1'b1;
        end else if (tx_enable) begin
          state_d = SHIFT;
          cnt_d   = CW'(CLK_DIV - 1);
          bit_d   = BW'(DATA_WIDTH - 1);
          // tx_sr holds the bits still to follow the one on MOSI
          tx_sr_d = {tx_data[DATA_WIDTH-2:0], 1'b0};
          mosi_d  = tx_data[DATA_WIDTH-1];
          sck_d   = 1'b0;
          cs_n_d  = 1'b0;
          busy_d  = 1'b1;
        end
      end
      SHIFT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          cnt_d = CW'(CLK_DIV - 1);
          if (!sck_q) begin
            sck_d   = 1'b1;
            rx_sr_d = {rx_sr_q[DATA_WIDTH-2:0], spi_miso};
          end else begin
            sck_d = 1'b0;
            if (bit_q == '0) begin
              state_d = HOLD;
            end else begin
              bit_d   = bit_q - 1'b1;
              mosi_d  = tx_sr_q[DATA_WIDTH-1];
              tx_sr_d = {tx_sr_q[DATA_WIDTH-2:0], 1'b0};
            end
          end
        end
      end
      HOLD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          cs_n_d    = 1'b1;
          done_d    = 1'b1;
          rx_data_d = rx_sr_q;
          // the done cycle is the first of the CS_IDLE high cycles
          if (CS_IDLE > 1) begin
            state_d = GAP;
            cnt_d   = CW'(CS_IDLE - 2);
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end
      end
      GAP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      CLEAR: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = IDLE;
          clr_n_d = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign spi_sck   = sck_q;
  assign spi_mosi  = mosi_q;
  assign dac_cs_n  = cs_n_q;
  assign dac_clr_n = clr_n_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign rx_data   = rx_data_q;

endmodule

// File: tb/tb_spi_dac_master.sv
// Directed bench for spi_dac_master: framing, timing, clear, busy
// rejection and asynchronous reset, with default parameters.
module tb_spi_dac_master;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] tx_data = '0;
  logic        tx_enable = 1'b0;
  logic        clr_req = 1'b0;
  logic        spi_miso = 1'b0;
  logic        spi_sck;
  logic        spi_mosi;
  logic        dac_cs_n;
  logic        dac_clr_n;
  logic        busy;
  logic        done;
  logic [31:0] rx_data;

  int total = 0;
  int bad = 0;

  logic [31:0] pat = '0;
  logic [31:0] mosi_word = '0;
  int          rises = 0;
  int          tot_rises = 0;
  logic        sck_prev = 1'b0;
  logic        cs_prev = 1'b1;

  spi_dac_master dut (
    .clk       (clk),
    .reset     (reset),
    .tx_data   (tx_data),
    .tx_enable (tx_enable),
    .clr_req   (clr_req),
    .spi_miso  (spi_miso),
    .spi_sck   (spi_sck),
    .spi_mosi  (spi_mosi),
    .dac_cs_n  (dac_cs_n),
    .dac_clr_n (dac_clr_n),
    .busy      (busy),
    .done      (done),
    .rx_data   (rx_data)
  );

  always #5 clk = ~clk;

  // DAC model: mode 0, shifts MISO out MSB-first, samples MOSI on SCK rise
  always @(posedge clk) begin
    #2;
    if (!dac_cs_n && cs_prev) begin
      rises    = 0;
      spi_miso = pat[31];
    end
    if (spi_sck && !sck_prev) begin
      mosi_word = {mosi_word[30:0], spi_mosi};
      rises     = rises + 1;
      tot_rises = tot_rises + 1;
      spi_miso  = (rises < 32) ? pat[31-rises] : 1'b0;
    end
    sck_prev = spi_sck;
    cs_prev  = dac_cs_n;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_frame(input logic [31:0] d, input logic [31:0] p,
                          input bit inject);
    int cs_low;
    int done_cyc;
    int done_cnt;
    logic cs_at_done;
    cs_low = 0;
    done_cyc = 0;
    done_cnt = 0;
    cs_at_done = 1'b0;
    pat = p;
    tx_data = d;
    tx_enable = 1'b1;
    @(negedge clk);
    tx_enable = 1'b0;
    tx_data = 32'hDEAD_BEEF;
    chk("c1_cs_n", {31'd0, dac_cs_n}, 32'd0);
    chk("c1_mosi", {31'd0, spi_mosi}, {31'd0, d[31]});
    chk("c1_busy", {31'd0, busy}, 32'd1);
    for (int c = 1; c <= 140; c++) begin
      if (!dac_cs_n) cs_low++;
      if (done) begin
        done_cnt++;
        done_cyc = c;
        cs_at_done = dac_cs_n;
      end
      if (inject && c == 50) begin
        tx_enable = 1'b1;
        tx_data = 32'hFFFF_FFFF;
      end
      if (inject && c == 51) tx_enable = 1'b0;
      @(negedge clk);
    end
    chk("cs_low_cycles", cs_low, 130);
    chk("done_cycle", done_cyc, 131);
    chk("done_count", done_cnt, 1);
    chk("cs_at_done", {31'd0, cs_at_done}, 32'd1);
    chk("sck_rises", rises, 32);
    chk("mosi_word", mosi_word, d);
    chk("rx_data", rx_data, p);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_cs_n", {31'd0, dac_cs_n}, 32'd1);
  endtask

  initial begin
    int r0;
    int done_cyc;
    int fall;
    int clr_low;
    int first_low;
    int busy_cnt;
    int cs_low;
    int done_cnt;

    // reset held with tx_enable high
    tx_enable = 1'b1;
    r0 = tot_rises;
    repeat (3) @(negedge clk);
    chk("rst_cs_n", {31'd0, dac_cs_n}, 32'd1);
    chk("rst_clr_n", {31'd0, dac_clr_n}, 32'd1);
    chk("rst_sck", {31'd0, spi_sck}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_rx", rx_data, 32'd0);
    chk("rst_sck_edges", tot_rises - r0, 0);
    tx_enable = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // single frame with an ignored mid-frame request
    do_frame(32'h0030_0ABC, 32'hA5A5_5A5A, 1'b1);

    // held tx_enable: next CS falls CS_IDLE cycles after done
    tx_data = 32'h00AA_5501;
    tx_enable = 1'b1;
    done_cyc = 0;
    fall = 0;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      if (done && done_cyc == 0) done_cyc = c;
      if (done_cyc != 0 && fall == 0 && c > done_cyc && !dac_cs_n) begin
        fall = c;
        tx_enable = 1'b0;
      end
    end
    chk("held_done_cycle", done_cyc, 131);
    chk("held_cs_gap", fall - done_cyc, 2);
    chk("held_idle", {31'd0, busy}, 32'd0);

    // clear pulse
    clr_req = 1'b1;
    clr_low = 0;
    first_low = 0;
    busy_cnt = 0;
    cs_low = 0;
    done_cnt = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      clr_req = 1'b0;
      if (!dac_clr_n) begin
        clr_low++;
        if (first_low == 0) first_low = c;
      end
      if (busy) busy_cnt++;
      if (!dac_cs_n) cs_low++;
      if (done) done_cnt++;
    end
    chk("clr_low_cycles", clr_low, 4);
    chk("clr_first_cycle", first_low, 1);
    chk("clr_busy_cycles", busy_cnt, 4);
    chk("clr_cs_low", cs_low, 0);
    chk("clr_done", done_cnt, 0);

    // clr_req and tx_enable together, tx_enable held
    clr_req = 1'b1;
    tx_enable = 1'b1;
    tx_data = 32'h0F0F_F0F0;
    fall = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      clr_req = 1'b0;
      if (c == 1) chk("sim_clr_first", {31'd0, dac_clr_n}, 32'd0);
      if (!dac_cs_n && fall == 0) begin
        fall = c;
        tx_enable = 1'b0;
      end
    end
    chk("sim_frame_start", fall, 6);
    repeat (150) @(negedge clk);

    // clr_req and tx_enable together, both dropped
    clr_req = 1'b1;
    tx_enable = 1'b1;
    clr_low = 0;
    cs_low = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      clr_req = 1'b0;
      tx_enable = 1'b0;
      if (!dac_clr_n) clr_low++;
      if (!dac_cs_n) cs_low++;
    end
    chk("sim2_clr_low", clr_low, 4);
    chk("sim2_no_frame", cs_low, 0);

    // asynchronous reset mid-frame
    tx_data = 32'hCAFE_F00D;
    tx_enable = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      tx_enable = 1'b0;
    end
    reset = 1'b0;
    #1;
    chk("arst_cs_n", {31'd0, dac_cs_n}, 32'd1);
    chk("arst_sck", {31'd0, spi_sck}, 32'd0);
    chk("arst_mosi", {31'd0, spi_mosi}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_rx", rx_data, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    done_cnt = 0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    chk("arst_no_done", done_cnt, 0);

    do_frame(32'h1234_5678, 32'h3C3C_0F0F, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_dac_master.md
Name: spi_dac_master

Overview:
- SPI master stage directly downstream of the DAC command generator. It consumes the generator's 32-bit command word (`toSPI`), its send strobe (`toEnable`) and its clear request (`toReset`).
- Serialises each command MSB-first to the board DAC in SPI mode 0, with chip-select framing.
- Generates the DAC asynchronous-clear pulse.
- Shifts in the DAC readback on MISO and returns `busy`/`done` status to the generator so it can pace commands.

Parameters:
DATA_WIDTH, 32, bits per SPI frame
CLK_DIV, 2, clk cycles per SCK half-period (>=1)
CLR_CYCLES, 4, clk cycles dac_clr_n held low per clear request (>=1)
CS_IDLE, 2, minimum clk cycles dac_cs_n stays high between frames (>=1)

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  asynchronous, active-low reset
tx_data  input  DATA_WIDTH  command word (from toSPI)
tx_enable  input  1  send request, level or pulse (from toEnable)
clr_req  input  1  DAC clear request (from toReset)
spi_miso  input  1  serial data from DAC
spi_sck  output  1  SPI clock, idles low
spi_mosi  output  1  serial data to DAC
dac_cs_n  output  1  DAC chip select, active low
dac_clr_n  output  1  DAC async clear, active low
busy  output  1  high from accept until back in IDLE, including CS_IDLE and clear time
done  output  1  one-cycle pulse at frame end
rx_data  output  DATA_WIDTH  bits captured from spi_miso during last frame

Behaviour:
- Reset (reset=0, asynchronous) forces:
  - state=IDLE; spi_sck=0, spi_mosi=0, dac_cs_n=1, dac_clr_n=1, busy=0, done=0, rx_data=0.
  - All counters cleared.
- Reset asserted mid-frame or mid-clear aborts immediately to these values. No done pulse. The partial frame is discarded.
- States: IDLE, SHIFT, HOLD, GAP, CLEAR.
- IDLE, evaluated each cycle (clr_req has priority):
  - clr_req=1 -> CLEAR.
  - else tx_enable=1 -> latch tx_data into the shift register, bit counter=DATA_WIDTH-1, then SHIFT.
  - The accept cycle is cycle 0. On cycle 1: dac_cs_n=0, spi_mosi=tx_data[MSB], busy=1.
- SHIFT:
  - Each bit is CLK_DIV cycles with SCK low, then CLK_DIV cycles with SCK high.
  - The SCK rising edge occurs CLK_DIV cycles after the MOSI update, which gives mosi setup of CLK_DIV cycles.
  - spi_miso is sampled into the rx shift register on the clk cycle that SCK goes high.
  - spi_mosi advances to the next bit on the SCK falling edge.
  - After DATA_WIDTH rising edges and the final high half-period: SCK=0, go to HOLD.
- HOLD:
  - dac_cs_n stays low for CLK_DIV cycles, with spi_mosi unchanged.
  - Then dac_cs_n=1, rx_data is updated with the captured word, done=1 for exactly that one cycle, and the state goes to GAP.
- Frame latency: done is asserted on cycle 1 + 2*CLK_DIV*DATA_WIDTH + CLK_DIV after accept. With defaults that is cycle 131.
- GAP:
  - dac_cs_n=1 for CS_IDLE cycles, counted from and including the done cycle; then IDLE.
  - busy drops on entry to IDLE.
- tx_enable and clr_req are ignored while busy=1. No queuing.
- A level-held tx_enable re-triggers a new frame on the first IDLE cycle.
- CLEAR:
  - dac_clr_n=0 for CLR_CYCLES cycles, starting the cycle after acceptance; dac_cs_n stays 1; busy=1.
  - Then dac_clr_n=1 and IDLE. No done pulse.
- tx_data may change after the accept cycle without affecting the frame in flight.
- spi_sck never glitches: it is a registered output and toggles only in SHIFT.

Test Plan:
- Reset check: hold reset=0 for 3 cycles with tx_enable=1 -> dac_cs_n=1, dac_clr_n=1, spi_sck=0, busy=0, rx_data=0; no SCK edges.
- Single frame, tx_data=32'h0030_0ABC, 1-cycle tx_enable (defaults):
  - dac_cs_n low on cycles 1..130 and high on cycle 131.
  - 32 SCK rising edges; MOSI bits sampled at those edges reproduce 0x00300ABC.
  - done=1 only on cycle 131.
  - spi_miso driven with 0xA5A5_5A5A -> rx_data=0xA5A55A5A at done.
- Busy rejection:
  - A tx_enable pulse with 0xFFFF_FFFF during a frame -> ignored.
  - Held tx_enable -> next frame's dac_cs_n falls exactly CS_IDLE(2) cycles after done.
- Clear: clr_req pulse in IDLE -> dac_clr_n low for exactly 4 cycles starting the next cycle; busy=1 throughout; dac_cs_n stays 1; no done.
- Simultaneous: clr_req=1 and tx_enable=1 in the same IDLE cycle -> CLEAR runs, no frame starts. A frame starts only if tx_enable is still high once back in IDLE.
- Mid-frame reset: assert reset=0 at cycle 60 of a frame -> outputs at reset values within the same cycle (asynchronous); no done. After release, a new frame with 0x1234_5678 transmits correctly.
